// File: rtl/ob_cntrl_dec.sv
// Order-book control decoder: registered instruction expansion into table
// strobes and operands, plus a small response FIFO toward egress.

package ob_pkg;
   typedef logic [7:0]  uid_t;
   typedef logic [15:0] qty_t;
   typedef logic [15:0] price_t;
   typedef logic [31:0] accum_t;

   typedef enum logic [1:0] {
      S_Okay       = 2'd0,
      S_Reject     = 2'd1,
      S_CancelHit  = 2'd2,
      S_CancelMiss = 2'd3
   } status_t;

   typedef struct packed {
      uid_t   uid;
      qty_t   quantity;
      price_t price;
   } table_t;

   typedef struct packed {
      logic   hit;
      uid_t   uid;
      price_t price;
      qty_t   quantity;
   } search_result_t;

   typedef struct packed {
      uid_t    uid;
      status_t status;
      accum_t  accum;
      price_t  bid_price;
      price_t  ask_price;
   } rsp_t;
endpackage

package ob_cntrl_pkg;
   import ob_pkg::*;

   typedef enum logic [3:0] {
      OP_NOP                   = 4'd0,
      OP_SEARCH_RESULT         = 4'd1,
      OP_EMIT_RSP              = 4'd2,
      OP_PUSH_TABLE            = 4'd3,
      OP_POP_TABLE             = 4'd4,
      OP_REJECT_POP            = 4'd5,
      OP_ISSUE_QRY             = 4'd6,
      OP_ISSUE_CANCEL          = 4'd7,
      OP_ISSUE_RSP_QRY_BID_ASK = 4'd8,
      OP_ISSUE_POP_TOP         = 4'd9
   } opcode_t;

   typedef enum logic [2:0] {
      TBL_ID__LM_ASK = 3'd0,
      TBL_ID__LM_BID = 3'd1,
      TBL_ID__MK_ASK = 3'd2,
      TBL_ID__MK_BID = 3'd3
   } table_id_t;

   // Operand views, all 45 bits wide (emit_rsp is the widest and sets the size).
   typedef struct packed { search_result_t sr; logic [3:0] pad; } op_search_result_t;
   typedef struct packed {
      uid_t uid; status_t status; logic set_accum; accum_t accum;
      logic lm_bid_reject_pop; logic lm_ask_reject_pop;
   } op_emit_rsp_t;
   typedef struct packed { table_id_t table_id; table_t cmd; logic [1:0] pad; } op_push_table_t;
   typedef struct packed { table_id_t table_id; logic [41:0] pad; } op_pop_table_t;
   typedef struct packed { table_id_t id; logic [41:0] pad; } op_pop_top_t;
   typedef struct packed { uid_t uid; logic is_ask; logic [35:0] pad; } op_reject_pop_t;
   typedef struct packed { logic is_ask; price_t price; qty_t quantity; logic [11:0] pad; } op_issue_qry_t;
   typedef struct packed { uid_t uid; logic [36:0] pad; } op_cancel_t;
   typedef struct packed {
      uid_t uid; status_t status; price_t bid_price; price_t ask_price; logic [2:0] pad;
   } op_rsp_qry_bid_ask_t;

   typedef union packed {
      op_search_result_t   search_result;
      op_emit_rsp_t        emit_rsp;
      op_push_table_t      push_table;
      op_pop_table_t       pop_table;
      op_pop_top_t         pop_top;
      op_reject_pop_t      reject_pop;
      op_issue_qry_t       issue_qry;
      op_cancel_t          cancel;
      op_rsp_qry_bid_ask_t rsp_qry_bid_ask;
   } oprand_t;

   typedef struct packed {
      opcode_t opcode;
      oprand_t oprand;
   } inst_t;

   typedef struct packed { price_t price; qty_t quantity; } qry_rsp_t;

   typedef struct packed {
      logic lm_ask_insert;   table_t lm_ask_insert_tbl;
      logic lm_bid_insert;   table_t lm_bid_insert_tbl;
      logic mk_ask_insert;   table_t mk_ask_insert_tbl;
      logic mk_bid_insert;   table_t mk_bid_insert_tbl;
      logic lm_ask_pop, lm_bid_pop, mk_ask_head_pop, mk_bid_head_pop;
      logic lm_ask_reject_pop, lm_bid_reject_pop;
      logic lm_ask_qry_rsp_vld, lm_bid_qry_rsp_vld;
      qry_rsp_t qry_rsp;
      logic lm_ask_cancel;   uid_t lm_ask_cancel_uid;
      logic lm_bid_cancel;   uid_t lm_bid_cancel_uid;
      logic mk_ask_cancel;   uid_t mk_ask_cancel_uid;
      logic mk_bid_cancel;   uid_t mk_bid_cancel_uid;
      logic rsp_vld;
      rsp_t rsp;
   } ucode_t;
endpackage

module ob_cntrl_dec
   import ob_pkg::*;
   import ob_cntrl_pkg::*;
#(
   parameter int RSP_Q_N = 2
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           inst_vld,
   input  inst_t          inst,
   output logic           inst_rdy,
   output ucode_t         uc,
   output logic           sr_vld,
   output search_result_t sr,
   output logic           rsp_vld,
   output rsp_t           rsp,
   input  logic           rsp_accept,
   output logic           err
);
   localparam int PTR_W = (RSP_Q_N > 2) ? $clog2(RSP_Q_N) : 1;
   localparam int CNT_W = PTR_W + 1;

   ucode_t         uc_q, uc_d;
   search_result_t sr_q, sr_d;
   logic           sr_vld_q, sr_vld_d;
   logic           err_q, err_d;

   rsp_t             mem_q [RSP_Q_N];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic      fire, illegal, enq, pop;
   rsp_t      enq_rsp;
   table_id_t tid;

   assign inst_rdy = (cnt_q != CNT_W'(RSP_Q_N));
   assign rsp_vld  = (cnt_q != '0);
   assign rsp      = mem_q[rd_ptr_q];
   assign fire     = inst_vld & inst_rdy;
   assign pop      = rsp_vld & rsp_accept;
   assign uc       = uc_q;
   assign sr       = sr_q;
   assign sr_vld   = sr_vld_q;
   assign err      = err_q;

   // Pick the table selector from whichever operand view the opcode uses.
   always_comb begin
      case (inst.opcode)
         OP_POP_TABLE:     tid = inst.oprand.pop_table.table_id;
         OP_ISSUE_POP_TOP: tid = inst.oprand.pop_top.id;
         default:          tid = inst.oprand.push_table.table_id;
      endcase
   end

   assign illegal = (inst.opcode > OP_ISSUE_POP_TOP) ||
                    ((inst.opcode inside {OP_PUSH_TABLE, OP_POP_TABLE, OP_ISSUE_POP_TOP}) &&
                     (tid > TBL_ID__MK_BID));
   assign err_d   = err_q | (fire & illegal);

   // Decode: strobes default low every cycle, operands hold unless rewritten.
   always_comb begin
      uc_d = uc_q;
      {uc_d.lm_ask_insert, uc_d.lm_bid_insert, uc_d.mk_ask_insert, uc_d.mk_bid_insert,
       uc_d.lm_ask_pop, uc_d.lm_bid_pop, uc_d.mk_ask_head_pop, uc_d.mk_bid_head_pop,
       uc_d.lm_ask_reject_pop, uc_d.lm_bid_reject_pop,
       uc_d.lm_ask_qry_rsp_vld, uc_d.lm_bid_qry_rsp_vld,
       uc_d.lm_ask_cancel, uc_d.lm_bid_cancel, uc_d.mk_ask_cancel, uc_d.mk_bid_cancel} = '0;
      uc_d.rsp_vld = 1'b0;
      uc_d.rsp     = '0;
      sr_d     = sr_q;
      sr_vld_d = 1'b0;
      enq      = 1'b0;
      enq_rsp  = '0;
      if (fire && !illegal) begin
         case (inst.opcode)
            OP_SEARCH_RESULT: begin
               sr_vld_d = 1'b1;
               sr_d     = inst.oprand.search_result.sr;
            end
            OP_EMIT_RSP: begin
               enq            = 1'b1;
               enq_rsp.uid    = inst.oprand.emit_rsp.uid;
               enq_rsp.status = inst.oprand.emit_rsp.status;
               enq_rsp.accum  = inst.oprand.emit_rsp.set_accum ? inst.oprand.emit_rsp.accum : '0;
               uc_d.lm_bid_reject_pop = inst.oprand.emit_rsp.lm_bid_reject_pop;
               uc_d.lm_ask_reject_pop = inst.oprand.emit_rsp.lm_ask_reject_pop;
            end
            OP_PUSH_TABLE: begin
               case (tid)
                  TBL_ID__LM_ASK: begin uc_d.lm_ask_insert = 1'b1; uc_d.lm_ask_insert_tbl = inst.oprand.push_table.cmd; end
                  TBL_ID__LM_BID: begin uc_d.lm_bid_insert = 1'b1; uc_d.lm_bid_insert_tbl = inst.oprand.push_table.cmd; end
                  TBL_ID__MK_ASK: begin uc_d.mk_ask_insert = 1'b1; uc_d.mk_ask_insert_tbl = inst.oprand.push_table.cmd; end
                  TBL_ID__MK_BID: begin uc_d.mk_bid_insert = 1'b1; uc_d.mk_bid_insert_tbl = inst.oprand.push_table.cmd; end
                  default: ;
               endcase
            end
            OP_POP_TABLE, OP_ISSUE_POP_TOP: begin
               case (tid)
                  TBL_ID__LM_ASK: uc_d.lm_ask_pop      = 1'b1;
                  TBL_ID__LM_BID: uc_d.lm_bid_pop      = 1'b1;
                  TBL_ID__MK_ASK: uc_d.mk_ask_head_pop = 1'b1;
                  TBL_ID__MK_BID: uc_d.mk_bid_head_pop = 1'b1;
                  default: ;
               endcase
            end
            OP_REJECT_POP: begin
               uc_d.lm_ask_reject_pop = inst.oprand.reject_pop.is_ask;
               uc_d.lm_bid_reject_pop = !inst.oprand.reject_pop.is_ask;
               enq            = 1'b1;
               enq_rsp.uid    = inst.oprand.reject_pop.uid;
               enq_rsp.status = S_Reject;
            end
            OP_ISSUE_QRY: begin
               uc_d.lm_ask_qry_rsp_vld = inst.oprand.issue_qry.is_ask;
               uc_d.lm_bid_qry_rsp_vld = !inst.oprand.issue_qry.is_ask;
               uc_d.qry_rsp.price      = inst.oprand.issue_qry.price;
               uc_d.qry_rsp.quantity   = inst.oprand.issue_qry.quantity;
            end
            OP_ISSUE_CANCEL: begin
               {uc_d.lm_ask_cancel, uc_d.lm_bid_cancel, uc_d.mk_ask_cancel, uc_d.mk_bid_cancel} = 4'hF;
               uc_d.lm_ask_cancel_uid = inst.oprand.cancel.uid;
               uc_d.lm_bid_cancel_uid = inst.oprand.cancel.uid;
               uc_d.mk_ask_cancel_uid = inst.oprand.cancel.uid;
               uc_d.mk_bid_cancel_uid = inst.oprand.cancel.uid;
            end
            OP_ISSUE_RSP_QRY_BID_ASK: begin
               enq               = 1'b1;
               enq_rsp.uid       = inst.oprand.rsp_qry_bid_ask.uid;
               enq_rsp.status    = inst.oprand.rsp_qry_bid_ask.status;
               enq_rsp.bid_price = inst.oprand.rsp_qry_bid_ask.bid_price;
               enq_rsp.ask_price = inst.oprand.rsp_qry_bid_ask.ask_price;
            end
            default: ;
         endcase
      end
   end

   // Decoded ucode, search result and sticky error registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         uc_q     <= '0;
         sr_q     <= '0;
         sr_vld_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         uc_q     <= uc_d;
         sr_q     <= sr_d;
         sr_vld_q <= sr_vld_d;
         err_q    <= err_d;
      end
   end

   // FIFO pointer/count next state; enqueue never hits a full FIFO because fire needs inst_rdy.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (enq) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({enq, pop})
         2'b10:   cnt_d = cnt_q + CNT_W'(1);
         2'b01:   cnt_d = cnt_q - CNT_W'(1);
         default: ;
      endcase
   end

   // FIFO control state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // FIFO storage; contents are only meaningful under cnt_q, so no reset needed.
   always_ff @(posedge clk) begin
      if (enq) mem_q[wr_ptr_q] <= enq_rsp;
   end
endmodule

// File: tb/tb_ob_cntrl_dec.sv
// Bench for ob_cntrl_dec: directed vector table, hand sequences for
// backpressure and async reset, then random traffic against a queue model.
module tb_ob_cntrl_dec;
   import ob_pkg::*;
   import ob_cntrl_pkg::*;

   localparam int N = 2;

   logic           clk = 1'b0;
   logic           rst, inst_vld, rsp_accept;
   inst_t          inst;
   logic           inst_rdy, sr_vld, rsp_vld, err;
   ucode_t         uc;
   search_result_t sr;
   rsp_t           rsp;

   int nvec = 0;
   int nbad = 0;

   always #5 clk = ~clk;

   ob_cntrl_dec #(.RSP_Q_N(N)) dut (
      .clk(clk), .rst(rst), .inst_vld(inst_vld), .inst(inst), .inst_rdy(inst_rdy),
      .uc(uc), .sr_vld(sr_vld), .sr(sr), .rsp_vld(rsp_vld), .rsp(rsp),
      .rsp_accept(rsp_accept), .err(err)
   );

   typedef struct {
      logic        vld;
      inst_t       inst;
      logic [15:0] stb;
      logic        srv;
      logic        rv;
      rsp_t        rsp;
      logic        err;
   } vec_t;
   vec_t tv[$];

   // strobe bit positions: 0..3 inserts (lm_ask,lm_bid,mk_ask,mk_bid), 4..7 pops,
   // 8 lm_ask_reject, 9 lm_bid_reject, 10 ask qry, 11 bid qry, 12..15 cancels
   function automatic logic [15:0] stb_of(input ucode_t u);
      return {u.mk_bid_cancel, u.mk_ask_cancel, u.lm_bid_cancel, u.lm_ask_cancel,
              u.lm_bid_qry_rsp_vld, u.lm_ask_qry_rsp_vld, u.lm_bid_reject_pop, u.lm_ask_reject_pop,
              u.mk_bid_head_pop, u.mk_ask_head_pop, u.lm_bid_pop, u.lm_ask_pop,
              u.mk_bid_insert, u.mk_ask_insert, u.lm_bid_insert, u.lm_ask_insert};
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      nvec++;
      if (act !== exp) begin
         nbad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // ---------------- instruction builders ----------------
   function automatic inst_t i_raw(input int op);
      inst_t x = '0;
      x.opcode = opcode_t'(op);
      return x;
   endfunction
   function automatic inst_t i_sr(input uid_t u, input price_t p, input qty_t q);
      inst_t x = i_raw(OP_SEARCH_RESULT);
      x.oprand.search_result.sr.hit      = 1'b1;
      x.oprand.search_result.sr.uid      = u;
      x.oprand.search_result.sr.price    = p;
      x.oprand.search_result.sr.quantity = q;
      return x;
   endfunction
   function automatic inst_t i_emit(input uid_t u, input status_t st, input logic sa,
                                    input accum_t a, input logic brej, input logic arej);
      inst_t x = i_raw(OP_EMIT_RSP);
      x.oprand.emit_rsp.uid               = u;
      x.oprand.emit_rsp.status            = st;
      x.oprand.emit_rsp.set_accum         = sa;
      x.oprand.emit_rsp.accum             = a;
      x.oprand.emit_rsp.lm_bid_reject_pop = brej;
      x.oprand.emit_rsp.lm_ask_reject_pop = arej;
      return x;
   endfunction
   function automatic inst_t i_push(input int tid, input uid_t u, input qty_t q, input price_t p);
      inst_t x = i_raw(OP_PUSH_TABLE);
      x.oprand.push_table.table_id     = table_id_t'(tid);
      x.oprand.push_table.cmd.uid      = u;
      x.oprand.push_table.cmd.quantity = q;
      x.oprand.push_table.cmd.price    = p;
      return x;
   endfunction
   function automatic inst_t i_pop(input int tid);
      inst_t x = i_raw(OP_POP_TABLE);
      x.oprand.pop_table.table_id = table_id_t'(tid);
      return x;
   endfunction
   function automatic inst_t i_top(input int tid);
      inst_t x = i_raw(OP_ISSUE_POP_TOP);
      x.oprand.pop_top.id = table_id_t'(tid);
      return x;
   endfunction
   function automatic inst_t i_rej(input uid_t u, input logic ask);
      inst_t x = i_raw(OP_REJECT_POP);
      x.oprand.reject_pop.uid    = u;
      x.oprand.reject_pop.is_ask = ask;
      return x;
   endfunction
   function automatic inst_t i_qry(input logic ask, input price_t p, input qty_t q);
      inst_t x = i_raw(OP_ISSUE_QRY);
      x.oprand.issue_qry.is_ask   = ask;
      x.oprand.issue_qry.price    = p;
      x.oprand.issue_qry.quantity = q;
      return x;
   endfunction
   function automatic inst_t i_cancel(input uid_t u);
      inst_t x = i_raw(OP_ISSUE_CANCEL);
      x.oprand.cancel.uid = u;
      return x;
   endfunction
   function automatic inst_t i_bidask(input uid_t u, input status_t st, input price_t b, input price_t a);
      inst_t x = i_raw(OP_ISSUE_RSP_QRY_BID_ASK);
      x.oprand.rsp_qry_bid_ask.uid       = u;
      x.oprand.rsp_qry_bid_ask.status    = st;
      x.oprand.rsp_qry_bid_ask.bid_price = b;
      x.oprand.rsp_qry_bid_ask.ask_price = a;
      return x;
   endfunction
   function automatic rsp_t mk_rsp(input uid_t u, input status_t st, input accum_t a,
                                   input price_t b, input price_t k);
      rsp_t r;
      r.uid = u; r.status = st; r.accum = a; r.bid_price = b; r.ask_price = k;
      return r;
   endfunction

   function automatic inst_t rand_inst();
      logic [63:0] r64 = {$urandom(), $urandom()};
      int          o   = $urandom_range(0, 10);
      int          t   = $urandom_range(0, 8);
      inst_t       x;
      x.oprand = oprand_t'(r64[44:0]);
      x.opcode = (o == 10) ? opcode_t'($urandom_range(10, 15)) : opcode_t'(o);
      if (o == int'(OP_PUSH_TABLE) || o == int'(OP_POP_TABLE))
         x.oprand.push_table.table_id = table_id_t'((t == 8) ? $urandom_range(4, 7) : t % 4);
      if (o == int'(OP_ISSUE_POP_TOP))
         x.oprand.pop_top.id = table_id_t'(t % 4);
      return x;
   endfunction

   // Reference model: what one accepted instruction should cause.
   function automatic void model(input inst_t i, output logic [15:0] stb, output logic srv,
                                 output logic ill, output logic push, output rsp_t r);
      int tid = int'(i.oprand.push_table.table_id);
      int op  = int'(i.opcode);
      stb = '0; srv = 1'b0; push = 1'b0; r = '0;
      ill = (op > 9) || ((op == 3 || op == 4 || op == 9) && tid > 3);
      if (ill) return;
      case (i.opcode)
         OP_SEARCH_RESULT: srv = 1'b1;
         OP_EMIT_RSP: begin
            push = 1'b1;
            r = mk_rsp(i.oprand.emit_rsp.uid, i.oprand.emit_rsp.status,
                       i.oprand.emit_rsp.set_accum ? i.oprand.emit_rsp.accum : 32'd0, 16'd0, 16'd0);
            stb[8] = i.oprand.emit_rsp.lm_ask_reject_pop;
            stb[9] = i.oprand.emit_rsp.lm_bid_reject_pop;
         end
         OP_PUSH_TABLE:                  stb[tid]     = 1'b1;
         OP_POP_TABLE, OP_ISSUE_POP_TOP: stb[4 + tid] = 1'b1;
         OP_REJECT_POP: begin
            stb[i.oprand.reject_pop.is_ask ? 8 : 9] = 1'b1;
            push = 1'b1;
            r = mk_rsp(i.oprand.reject_pop.uid, S_Reject, 32'd0, 16'd0, 16'd0);
         end
         OP_ISSUE_QRY:    stb[i.oprand.issue_qry.is_ask ? 10 : 11] = 1'b1;
         OP_ISSUE_CANCEL: stb[15:12] = 4'hF;
         OP_ISSUE_RSP_QRY_BID_ASK: begin
            push = 1'b1;
            r = mk_rsp(i.oprand.rsp_qry_bid_ask.uid, i.oprand.rsp_qry_bid_ask.status, 32'd0,
                       i.oprand.rsp_qry_bid_ask.bid_price, i.oprand.rsp_qry_bid_ask.ask_price);
         end
         default: ;
      endcase
   endfunction

   // Check strobes, and the operands belonging to any strobe that is expected high.
   task automatic check_uc(input logic [15:0] es, input logic esrv, input inst_t ei);
      chk("strobes", stb_of(uc), es);
      chk("sr_vld", sr_vld, esrv);
      chk("uc.rsp_vld", uc.rsp_vld, 1'b0);
      if (es[0]) chk("lm_ask_insert_tbl", uc.lm_ask_insert_tbl, ei.oprand.push_table.cmd);
      if (es[1]) chk("lm_bid_insert_tbl", uc.lm_bid_insert_tbl, ei.oprand.push_table.cmd);
      if (es[2]) chk("mk_ask_insert_tbl", uc.mk_ask_insert_tbl, ei.oprand.push_table.cmd);
      if (es[3]) chk("mk_bid_insert_tbl", uc.mk_bid_insert_tbl, ei.oprand.push_table.cmd);
      if (es[10] || es[11]) begin
         chk("qry_price", uc.qry_rsp.price, ei.oprand.issue_qry.price);
         chk("qry_qty", uc.qry_rsp.quantity, ei.oprand.issue_qry.quantity);
      end
      if (es[12]) chk("cancel_uids",
                      {uc.lm_ask_cancel_uid, uc.lm_bid_cancel_uid, uc.mk_ask_cancel_uid, uc.mk_bid_cancel_uid},
                      {4{ei.oprand.cancel.uid}});
      if (esrv) chk("sr", sr, ei.oprand.search_result.sr);
   endtask

   task automatic add(input logic v, input inst_t i, input logic [15:0] s, input logic srv,
                      input logic rv, input rsp_t r, input logic e);
      vec_t x;
      x.vld = v; x.inst = i; x.stb = s; x.srv = srv; x.rv = rv; x.rsp = r; x.err = e;
      tv.push_back(x);
   endtask

   rsp_t        q[$];
   logic        m_err, fire, popm, ill, push, e_srv;
   logic [15:0] e_stb;
   rsp_t        r;
   inst_t       e_inst;

   initial begin
      // ---------------- vector table ----------------
      add(1, i_push(1, 8'd5, 16'd10, 16'h0100), 16'h0002, 0, 0, '0, 0);
      add(0, '0,                                16'h0000, 0, 0, '0, 0);
      add(1, i_emit(8'd7, S_Okay, 1, 32'd42, 0, 0), 16'h0000, 0, 1, mk_rsp(8'd7, S_Okay, 32'd42, 0, 0), 0);
      add(0, '0,                                16'h0000, 0, 0, '0, 0);
      add(1, i_rej(8'd9, 1),                    16'h0100, 0, 1, mk_rsp(8'd9, S_Reject, 0, 0, 0), 0);
      add(1, i_emit(8'd11, S_Okay, 0, 32'd99, 1, 0), 16'h0200, 0, 1, mk_rsp(8'd11, S_Okay, 0, 0, 0), 0);
      add(1, i_pop(2),                          16'h0040, 0, 0, '0, 0);
      add(1, i_top(0),                          16'h0010, 0, 0, '0, 0);
      add(1, i_qry(0, 16'h0055, 16'd3),         16'h0800, 0, 0, '0, 0);
      add(1, i_cancel(8'd3),                    16'hF000, 0, 0, '0, 0);
      add(1, i_sr(8'd44, 16'h0123, 16'd17),     16'h0000, 1, 0, '0, 0);
      add(1, i_bidask(8'd12, S_Okay, 16'h0010, 16'h0020), 16'h0000, 0, 1,
          mk_rsp(8'd12, S_Okay, 0, 16'h0010, 16'h0020), 0);
      add(1, i_push(3, 8'd66, 16'd2, 16'h0777), 16'h0008, 0, 0, '0, 0);
      add(1, i_raw(OP_NOP),                     16'h0000, 0, 0, '0, 0);
      add(1, i_raw(15),                         16'h0000, 0, 0, '0, 1);
      add(1, i_pop(4),                          16'h0000, 0, 0, '0, 1);
      add(1, i_cancel(8'd3),                    16'hF000, 0, 0, '0, 1);
      add(0, '0,                                16'h0000, 0, 0, '0, 1);

      // ---------------- reset state ----------------
      rst = 1'b1; inst_vld = 1'b0; inst = '0; rsp_accept = 1'b0;
      @(negedge clk);
      chk("rst inst_rdy", inst_rdy, 1'b1);
      chk("rst rsp_vld", rsp_vld, 1'b0);
      chk("rst err", err, 1'b0);
      chk("rst strobes", stb_of(uc), 16'h0);
      chk("rst sr_vld", sr_vld, 1'b0);
      chk("rst sr", sr, '0);
      chk("rst tbl operand", uc.lm_bid_insert_tbl, '0);
      @(negedge clk);
      rst = 1'b0;

      // ---------------- table ----------------
      rsp_accept = 1'b1;
      foreach (tv[k]) begin
         inst_vld = tv[k].vld;
         inst     = tv[k].inst;
         step();
         check_uc(tv[k].stb, tv[k].srv, tv[k].inst);
         chk("rsp_vld", rsp_vld, tv[k].rv);
         if (tv[k].rv) chk("rsp", rsp, tv[k].rsp);
         chk("err", err, tv[k].err);
      end

      // ---------------- backpressure: FIFO fills, stalls, drains in order ----------------
      rst = 1'b1; inst_vld = 1'b0; rsp_accept = 1'b0;
      @(negedge clk);
      chk("err cleared by rst", err, 1'b0);
      rst = 1'b0;
      inst_vld = 1'b1;
      inst = i_emit(8'd1, S_Okay, 1, 32'd100, 0, 0);
      step();
      chk("bp rdy after 1", inst_rdy, 1'b1);
      chk("bp head uid 1", rsp.uid, 8'd1);
      inst = i_emit(8'd2, S_Okay, 1, 32'd200, 0, 0);
      step();
      chk("bp rdy full", inst_rdy, 1'b0);
      chk("bp rsp_vld full", rsp_vld, 1'b1);
      inst = i_emit(8'd3, S_Okay, 1, 32'd300, 0, 0);
      step();
      chk("bp rdy stalled", inst_rdy, 1'b0);
      chk("bp head held", rsp, mk_rsp(8'd1, S_Okay, 32'd100, 0, 0));
      rsp_accept = 1'b1;
      step();
      chk("bp rdy after pop", inst_rdy, 1'b1);
      chk("bp head uid 2", rsp, mk_rsp(8'd2, S_Okay, 32'd200, 0, 0));
      step();
      chk("bp head uid 3", rsp, mk_rsp(8'd3, S_Okay, 32'd300, 0, 0));
      inst_vld = 1'b0;
      step();
      chk("bp drained", rsp_vld, 1'b0);

      // ---------------- random traffic vs model ----------------
      m_err = 1'b0; e_stb = '0; e_srv = 1'b0; e_inst = '0; q.delete();
      for (int c = 0; c < 500; c++) begin
         check_uc(e_stb, e_srv, e_inst);
         chk("rnd inst_rdy", inst_rdy, q.size() < N);
         chk("rnd rsp_vld", rsp_vld, q.size() > 0);
         if (q.size() > 0) chk("rnd rsp", rsp, q[0]);
         chk("rnd err", err, m_err);
         inst_vld   = ($urandom_range(0, 3) != 0);
         inst       = rand_inst();
         rsp_accept = ($urandom_range(0, 2) != 0);
         fire = inst_vld && (q.size() < N);
         popm = rsp_accept && (q.size() > 0);
         if (fire) model(inst, e_stb, e_srv, ill, push, r);
         else begin e_stb = '0; e_srv = 1'b0; ill = 1'b0; push = 1'b0; end
         e_inst = inst;
         if (popm) void'(q.pop_front());
         if (push) q.push_back(r);
         if (ill) m_err = 1'b1;
         step();
      end

      // ---------------- async reset with an entry queued and a strobe pending ----------------
      rsp_accept = 1'b0;
      inst_vld = 1'b1;
      inst = i_raw(15);
      step();
      step();
      inst = i_emit(8'd20, S_Okay, 0, 32'd0, 1, 1);
      step();
      chk("pre-rst err", err, 1'b1);
      chk("pre-rst rsp_vld", rsp_vld, 1'b1);
      chk("pre-rst strobes", stb_of(uc), 16'h0300);
      inst_vld = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("async rst rsp_vld", rsp_vld, 1'b0);
      chk("async rst strobes", stb_of(uc), 16'h0);
      chk("async rst err", err, 1'b0);
      chk("async rst inst_rdy", inst_rdy, 1'b1);
      @(negedge clk);
      rst = 1'b0;
      step();

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
      $finish;
   end
endmodule

// File: doc/ob_cntrl_dec.md
Name: ob_cntrl_dec

Overview:
- Registered instruction decoder between the central control state machine and the limit/market tables and response egress.
- Accepts one ob_cntrl_pkg::inst_t per cycle on a valid/ready handshake and expands it into single-cycle table side-effect strobes, with their operands, per the ob_cntrl_pkg::ucode_t field set.
- Response-producing opcodes are enqueued into an internal response FIFO that drains to egress under rsp_accept backpressure.

Parameters:
- RSP_Q_N, 2: response FIFO depth in entries; minimum 2, power of two.

Ports:
- clk  in  1  clock.
- rst  in  1  reset: asynchronous, active-high.
- inst_vld  in  1  instruction valid.
- inst  in  $bits(ob_cntrl_pkg::inst_t)  instruction word.
- inst_rdy  out  1  decoder can accept; equals !rsp_q_full, no combinational path from inst or rsp_accept.
- uc  out  $bits(ob_cntrl_pkg::ucode_t)  registered ucode; all fields except rsp_vld/rsp are driven here. uc.rsp_vld is tied 0.
- sr_vld  out  1  search-result pulse.
- sr  out  $bits(ob_pkg::search_result_t)  latched search result.
- rsp_vld  out  1  head of response FIFO valid.
- rsp  out  $bits(ob_pkg::rsp_t)  response FIFO head.
- rsp_accept  in  1  egress consumes head this cycle when rsp_vld=1.
- err  out  1  sticky illegal-instruction flag.

Behaviour:
- Accept: fire = inst_vld & inst_rdy.
- Strobes and operands register on the edge after fire: 1-cycle latency, 1-cycle pulse. All strobes are 0 in any cycle not following a fire.
- Operand fields hold their last value between fires; they are don't-care when the matching strobe is 0.
- Decode by opcode:
  - OP_NOP: nothing.
  - OP_SEARCH_RESULT: sr <= oprand.search_result.sr; sr_vld pulses.
  - OP_EMIT_RSP: enqueue {uid, status, accum = set_accum ? accum : 0}. lm_bid_reject_pop and lm_ask_reject_pop pulse per their oprand bits.
  - OP_PUSH_TABLE: by table_id, pulse one of lm_ask_insert, lm_bid_insert, mk_ask_insert or mk_bid_insert. The matching *_insert_tbl is set from cmd (uid, quantity, price copied).
  - OP_POP_TABLE and OP_ISSUE_POP_TOP: by table_id (or pop_top.id), pulse lm_ask_pop, lm_bid_pop, mk_ask_head_pop or mk_bid_head_pop.
  - OP_REJECT_POP: pulse lm_ask_reject_pop if is_ask, else lm_bid_reject_pop. Enqueue {uid, S_Reject, accum 0}.
  - OP_ISSUE_QRY: pulse lm_ask_qry_rsp_vld if is_ask, else lm_bid_qry_rsp_vld, with price and quantity.
  - OP_ISSUE_CANCEL: pulse all four *_cancel with *_cancel_uid = uid.
  - OP_ISSUE_RSP_QRY_BID_ASK: enqueue {uid, status, bid_price, ask_price}.
- Illegal instruction: opcode > OP_ISSUE_POP_TOP, or table_id > TBL_ID__MK_BID on a push/pop.
  - Sets err (sticky until rst).
  - Instruction is consumed (fire still occurs) with no strobes and no enqueue.
- Response FIFO:
  - Circular buffer with wr_ptr, rd_ptr and count in 0..RSP_Q_N.
  - Enqueue when fire carries a response opcode; the entry is visible at the next edge, so first rsp_vld appears 1 cycle after fire.
  - Pop when rsp_vld & rsp_accept.
  - Simultaneous enqueue and pop: count unchanged; legal at any count, including full, but inst_rdy=0 when full, so enqueue cannot coincide with full.
  - Pointers wrap modulo RSP_Q_N. rsp holds stable while rsp_vld=1 and rsp_accept=0.
- inst_rdy = (count != RSP_Q_N). It applies to all opcodes, including non-response ones.
- Reset (async assert, sync release):
  - All strobes, sr_vld, rsp_vld, err and count reset to 0; pointers reset to 0; inst_rdy=1.
  - Operand and sr registers reset to '0.
  - Reset mid-stream discards FIFO contents and any in-flight strobe.

Test Plan:
- Reset then fire OP_PUSH_TABLE with cmd {uid=5, qty=10, price=0x0100}, table_id=TBL_ID__LM_BID → exactly one cycle later lm_bid_insert=1 and lm_bid_insert_tbl.uid=5; the next cycle all strobes are 0.
- OP_EMIT_RSP {uid=7, S_Okay, set_accum=1, accum=42} with rsp_accept=1 → rsp_vld at fire+1 with {7, S_Okay, 42}; the FIFO empties the following cycle.
- Hold rsp_accept=0 and fire 2 response ops (uid 1, 2) → inst_rdy=0 after the second. A third inst_vld stalls. Raising rsp_accept pops uid 1, then uid 2, in order; inst_rdy returns 1 the cycle after the first pop.
- OP_REJECT_POP {uid=9, is_ask=1} → lm_ask_reject_pop pulse and rsp {9, S_Reject}; lm_bid_reject_pop stays 0.
- Opcode 4'b1111, then OP_POP_TABLE with table_id=3'b100 → err=1 and stays 1, no strobes. A subsequent valid OP_ISSUE_CANCEL uid=3 still pulses all four cancels with uid 3.
- Assert rst asynchronously with 1 FIFO entry and a pending strobe → rsp_vld=0, strobes=0, err=0 immediately, without waiting for a clock edge.
